// File: rtl/ysyx_22040228_if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one request in flight
// to instruction memory, and hands {pc, inst} to IF/ID with redirect/stall handling.
module ysyx_22040228_if_fetch #(
    parameter int unsigned     PC_W     = 64,
    parameter int unsigned     INST_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(64'h0000_0000_8000_0000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              stall,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [PC_W-1:0]   imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    output logic              imem_resp_ready,
    output logic [PC_W-1:0]   if_pc,
    output logic [INST_W-1:0] if_inst,
    output logic              if_inst_valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t            state;
    logic [PC_W-1:0]   pc_r;
    logic              pend;
    logic [INST_W-1:0] inst_buf;

    logic [PC_W-1:0]   tgt;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   pc_next;

    // Redirect target is forced word aligned; pc_next is the PC to refetch after a discard.
    assign tgt     = redirect_pc & ~PC_W'(3);
    assign pc_inc  = pc_r + PC_W'(4);
    assign pc_next = redirect_valid ? tgt : pc_r;

    // pc_r tracks the next architectural fetch PC; imem_req_addr is a separate copy
    // frozen while a request waits for acceptance, so a redirect can update pc_r at once
    // and only the in-flight response needs discarding (pend).
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            pc_r            <= RESET_PC;
            pend            <= 1'b0;
            inst_buf        <= '0;
            imem_req_valid  <= 1'b0;
            imem_req_addr   <= '0;
            imem_resp_ready <= 1'b0;
            if_pc           <= '0;
            if_inst         <= '0;
            if_inst_valid   <= 1'b0;
        end else begin
            if_inst_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    pc_r           <= pc_next;
                    imem_req_addr  <= pc_next;
                    imem_req_valid <= 1'b1;
                    state          <= S_REQ;
                end
                S_REQ: begin
                    if (redirect_valid) begin
                        pc_r <= tgt;
                        pend <= 1'b1;
                    end
                    if (imem_req_ready) begin
                        imem_req_valid  <= 1'b0;
                        imem_resp_ready <= 1'b1;
                        state           <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        imem_resp_ready <= 1'b0;
                        pend            <= 1'b0;
                        if (pend || redirect_valid) begin
                            pc_r           <= pc_next;
                            imem_req_addr  <= pc_next;
                            imem_req_valid <= 1'b1;
                            state          <= S_REQ;
                        end else if (!stall) begin
                            if_pc          <= pc_r;
                            if_inst        <= imem_resp_data;
                            if_inst_valid  <= 1'b1;
                            pc_r           <= pc_inc;
                            imem_req_addr  <= pc_inc;
                            imem_req_valid <= 1'b1;
                            state          <= S_REQ;
                        end else begin
                            inst_buf <= imem_resp_data;
                            state    <= S_HOLD;
                        end
                    end else if (redirect_valid) begin
                        pc_r <= tgt;
                        pend <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        pc_r           <= tgt;
                        imem_req_addr  <= tgt;
                        imem_req_valid <= 1'b1;
                        state          <= S_REQ;
                    end else if (!stall) begin
                        if_pc          <= pc_r;
                        if_inst        <= inst_buf;
                        if_inst_valid  <= 1'b1;
                        pc_r           <= pc_inc;
                        imem_req_addr  <= pc_inc;
                        imem_req_valid <= 1'b1;
                        state          <= S_REQ;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040228_if_fetch.sv
// Bench for the fetch stage: behavioural instruction memory plus an in-order
// scoreboard of expected fetch PCs, driven by directed cases and random traffic.
module tb_ysyx_22040228_if_fetch;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_ready;
    logic [63:0] if_pc;
    logic [31:0] if_inst;
    logic        if_inst_valid;

    ysyx_22040228_if_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .imem_resp_ready(imem_resp_ready),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_inst_valid  (if_inst_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model state
    int          ready_mode = 1;   // 0 random, 1 always ready, 2 never ready
    int          lat_fix    = 0;   // <0 selects random latency 0..3
    logic        mem_busy   = 1'b0;
    logic [63:0] mem_addr   = '0;
    int          mem_cnt    = 0;

    // Reference model: next PC the stage must deliver, and last delivered pair
    logic [63:0] exp_pc    = RESET_PC;
    logic [63:0] last_pc   = '0;
    logic [31:0] last_inst = '0;
    int          deliv_cnt = 0;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[33:2] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_mode(input int m);
        ready_mode     = m;
        imem_req_ready = (m != 2);
    endtask

    // One clock: capture pre-edge handshakes, step memory + model, check outputs, drive next inputs.
    task automatic tick();
        logic        p_rst, p_req_hs, p_req_wait, p_resp_hs, p_red, p_stall, p_busy;
        logic [63:0] p_addr, p_red_pc;
        p_rst      = rst;
        p_req_hs   = imem_req_valid && imem_req_ready;
        p_req_wait = imem_req_valid && !imem_req_ready;
        p_resp_hs  = imem_resp_valid && imem_resp_ready;
        p_red      = redirect_valid;
        p_red_pc   = redirect_pc;
        p_stall    = stall;
        p_addr     = imem_req_addr;
        p_busy     = mem_busy;
        @(posedge clk);
        #1;
        if (p_rst) begin
            mem_busy = 1'b0;
            check("rst_inst_valid", 64'(if_inst_valid), 64'd0);
            check("rst_req_valid", 64'(imem_req_valid), 64'd0);
            check("rst_resp_ready", 64'(imem_resp_ready), 64'd0);
            check("rst_if_pc", if_pc, 64'd0);
            check("rst_if_inst", 64'(if_inst), 64'd0);
            exp_pc    = RESET_PC;
            last_pc   = '0;
            last_inst = '0;
        end else begin
            if (p_resp_hs) mem_busy = 1'b0;
            if (p_req_hs) begin
                check("single_outstanding", 64'(p_busy && !p_resp_hs), 64'd0);
                mem_busy = 1'b1;
                mem_addr = p_addr;
                mem_cnt  = (lat_fix < 0) ? int'($urandom_range(3)) : lat_fix;
            end else if (mem_busy && mem_cnt > 0) begin
                mem_cnt--;
            end
            if (p_req_wait) begin
                check("req_valid_held", 64'(imem_req_valid), 64'd1);
                check("req_addr_held", imem_req_addr, p_addr);
            end
            if (p_red) exp_pc = p_red_pc & ~64'd3;
            if (if_inst_valid) begin
                check("deliver_while_stalled", 64'(p_stall), 64'd0);
                check("deliver_pc", if_pc, exp_pc);
                check("deliver_inst", 64'(if_inst), 64'(inst_of(exp_pc)));
                last_pc   = exp_pc;
                last_inst = inst_of(exp_pc);
                exp_pc    = exp_pc + 64'd4;
                deliv_cnt++;
            end else begin
                check("hold_if_pc", if_pc, last_pc);
                check("hold_if_inst", 64'(if_inst), 64'(last_inst));
            end
        end
        if (imem_req_valid) check("req_addr_aligned", 64'(imem_req_addr[1:0]), 64'd0);
        case (ready_mode)
            0:       imem_req_ready = ($urandom_range(99) < 70);
            1:       imem_req_ready = 1'b1;
            default: imem_req_ready = 1'b0;
        endcase
        imem_resp_valid = mem_busy && (mem_cnt == 0);
        imem_resp_data  = imem_resp_valid ? inst_of(mem_addr) : 32'($urandom);
        redirect_valid  = 1'b0;
    endtask

    task automatic redirect(input logic [63:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
    endtask

    task automatic wait_req(input string tag, input logic [63:0] addr);
        int i;
        for (i = 0; i < 20 && !imem_req_valid; i++) tick();
        if (!imem_req_valid) check({tag, "_timeout"}, 64'd0, 64'd1);
        else check(tag, imem_req_addr, addr);
    endtask

    task automatic wait_deliv(input string tag, input logic [63:0] pc);
        int i;
        tick();
        for (i = 0; i < 30 && !if_inst_valid; i++) tick();
        if (!if_inst_valid) check({tag, "_timeout"}, 64'd0, 64'd1);
        else check(tag, if_pc, pc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          d;
        int          gap;
        int          d0;
        logic [63:0] a0;
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        stall           = 1'b0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;

        // 1: reset, zero-wait memory, three sequential deliveries in 6 cycles
        set_mode(1);
        lat_fix = 0;
        repeat (3) tick();
        rst = 1'b0;
        d = deliv_cnt;
        wait_req("t1_first_req", RESET_PC);
        repeat (6) tick();
        check("t1_count", 64'(deliv_cnt - d), 64'd3);
        check("t1_last_pc", if_pc, RESET_PC + 64'd8);

        // 2: request held unaccepted for 5 cycles
        set_mode(2);
        a0 = imem_req_addr;
        d  = deliv_cnt;
        repeat (5) tick();
        check("t2_valid", 64'(imem_req_valid), 64'd1);
        check("t2_addr", imem_req_addr, a0);
        set_mode(1);
        tick();
        tick();
        check("t2_count", 64'(deliv_cnt - d), 64'd1);
        check("t2_pc", if_pc, a0);

        // 3: stall across the response, then one buffered delivery
        lat_fix = 1;
        stall   = 1'b1;
        d       = deliv_cnt;
        repeat (6) tick();
        check("t3_no_pulse", 64'(deliv_cnt - d), 64'd0);
        check("t3_hold_idle_bus", 64'(imem_req_valid | imem_resp_ready), 64'd0);
        stall = 1'b0;
        tick();
        check("t3_pulse", 64'(if_inst_valid), 64'd1);
        check("t3_count", 64'(deliv_cnt - d), 64'd1);

        // 4: redirect while waiting for a response
        lat_fix = 3;
        tick();
        check("t4_in_wait", 64'(imem_resp_ready), 64'd1);
        redirect(64'h0000_0000_8000_1002);
        wait_req("t4_req", 64'h0000_0000_8000_1000);
        wait_deliv("t4_deliv", 64'h0000_0000_8000_1000);

        // 5a: redirect while the request is not yet accepted
        set_mode(2);
        lat_fix = 0;
        a0 = imem_req_addr;
        tick();
        redirect(64'h0000_0000_8000_2000);
        tick();
        check("t5_addr_stable", imem_req_addr, a0);
        check("t5_valid_stable", 64'(imem_req_valid), 64'd1);
        set_mode(1);
        tick();
        tick();
        wait_req("t5_req_target", 64'h0000_0000_8000_2000);
        wait_deliv("t5_deliv", 64'h0000_0000_8000_2000);

        // 5b: redirect while holding a buffered instruction
        stall = 1'b1;
        repeat (3) tick();
        check("t5_in_hold", 64'(imem_req_valid | imem_resp_ready), 64'd0);
        redirect(64'h0000_0000_8000_3000);
        stall = 1'b0;
        wait_deliv("t5_hold_deliv", 64'h0000_0000_8000_3000);

        // 6: reset in WAIT and in HOLD, then PC wrap-around
        lat_fix = 3;
        tick();
        check("t6_in_wait", 64'(imem_resp_ready), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_req("t6_restart_req", RESET_PC);
        wait_deliv("t6_restart_deliv", RESET_PC);
        lat_fix = 0;
        stall   = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        stall = 1'b0;
        wait_req("t6_hold_restart_req", RESET_PC);
        wait_deliv("t6_hold_restart_deliv", RESET_PC);
        redirect(64'hFFFF_FFFF_FFFF_FFFC);
        wait_deliv("t6_wrap_top", 64'hFFFF_FFFF_FFFF_FFFC);
        wait_deliv("t6_wrap_zero", 64'd0);

        // Random traffic: memory backpressure/latency, stalls, redirects, occasional reset
        set_mode(0);
        lat_fix = -1;
        gap = 0;
        d0  = deliv_cnt;
        for (int i = 0; i < 3000; i++) begin
            stall = ($urandom_range(99) < 20);
            rst   = ($urandom_range(999) < 3);
            if ($urandom_range(99) < 3) begin
                redirect_valid = 1'b1;
                redirect_pc    = {32'h0000_0000, 4'h8, 12'h000, 16'($urandom)};
            end
            tick();
            if (if_inst_valid || rst) gap = 0;
            else gap++;
            if (gap == 200) check("liveness", 64'd0, 64'd1);
        end
        rst   = 1'b0;
        stall = 1'b0;
        check("random_progress", 64'(deliv_cnt - d0 > 300), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
